// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 device-to-host frame receiver.
// Synchronises and deglitches the raw PS/2 pins, decodes 11-bit frames
// (start, 8 data bits LSB first, odd parity, stop) and hands scan-code bytes
// to the core over valid/ready with a parity-error sideband.
// Optional feature macro: PS2_RX_FIFO_EN selects a FIFO_DEPTH-entry output
// FIFO; without it a single holding register stores one byte.
//
// Handshake: rx_valid is held high while an entry is present and rx_data /
// rx_parity_err stay stable; the entry is consumed on the clk edge where
// rx_valid & rx_ready are both high, and the next entry (if any) appears in
// the following cycle.
module ps2_kbd_rx #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_parity_err,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overflow,
    output logic       busy
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic          clk_meta, clk_sync, data_meta, data_sync;
    logic          clk_filt;
    logic [FW-1:0] filt_cnt;
    logic          fe;
    logic [1:0]    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          parity_bit;
    logic [TW-1:0] to_cnt;
    logic          timeout;
    logic          commit;
    logic          commit_perr;
    logic          pop;

    // Two-flop synchronisers; idle-high bus so they reset to 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk;
            clk_sync  <= clk_meta;
            data_meta <= ps2_data;
            data_sync <= data_meta;
        end
    end

    // Clock filter: the level flips only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_sync != clk_filt) begin
            if (filt_cnt == FILT_MAX) begin
                clk_filt <= clk_sync;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end else begin
            filt_cnt <= '0;
        end
    end

    // Falling edge is flagged in the cycle the filtered level is about to drop.
    assign fe = clk_filt & ~clk_sync & (filt_cnt == FILT_MAX);

    // Inactivity timer; only runs mid-frame and restarts on every falling edge.
    always_ff @(posedge clk) begin
        if (rst || state == S_IDLE || fe) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout = (state != S_IDLE) && (to_cnt == TO_MAX);

    // Frame decoder FSM; a timeout overrides any edge in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (timeout) begin
                state     <= S_IDLE;
                frame_err <= 1'b1;
            end else if (fe) begin
                case (state)
                    S_IDLE: begin
                        if (!data_sync) begin
                            bit_cnt <= '0;
                            state   <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        shreg   <= {data_sync, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= S_PARITY;
                    end
                    S_PARITY: begin
                        parity_bit <= data_sync;
                        state      <= S_STOP;
                    end
                    S_STOP: begin
                        state <= S_IDLE;
                        if (!data_sync) frame_err <= 1'b1;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign commit      = fe && !timeout && (state == S_STOP) && data_sync;
    assign commit_perr = ~(^shreg ^ parity_bit);
    assign pop         = rx_valid & rx_ready;
    assign busy        = (state != S_IDLE);

`ifdef PS2_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    logic [8:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic        full, push;

    assign full = (count == FULL_CNT);
    assign push = commit & (~full | pop);

    // FIFO storage; a pop in the commit cycle frees the slot the commit needs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {commit_perr, shreg};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
            if (commit && full && !pop) overflow <= 1'b1;
        end
    end

    assign rx_valid      = (count != '0);
    assign rx_data       = mem[rd_ptr][7:0];
    assign rx_parity_err = mem[rd_ptr][8];
`else
    logic [7:0] hold_data;
    logic       hold_perr;
    logic       hold_valid;

    // Single holding register; a simultaneous pop lets the new byte replace the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_data  <= '0;
            hold_perr  <= 1'b0;
            hold_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (commit && (!hold_valid || pop)) begin
                hold_data  <= shreg;
                hold_perr  <= commit_perr;
                hold_valid <= 1'b1;
            end else if (pop) begin
                hold_valid <= 1'b0;
            end
            if (commit && hold_valid && !pop) overflow <= 1'b1;
        end
    end

    assign rx_valid      = hold_valid;
    assign rx_data       = hold_data;
    assign rx_parity_err = hold_perr;
`endif

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: directed PS/2 frames into ps2_kbd_rx with a scoreboard.
// Expected {parity_err, byte} entries are queued as frames are issued; a
// monitor pops and compares on every rx_valid & rx_ready beat.
module tb_ps2_kbd_rx;

    localparam int H       = 20;    // PS/2 half bit period in clk cycles
    localparam int TO      = 3000;
`ifdef PS2_RX_FIFO_EN
    localparam int CAP     = 4;
`else
    localparam int CAP     = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] rx_data;
    logic       rx_parity_err;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       frame_err;
    logic       overflow;
    logic       busy;

    logic [8:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int fe_cnt = 0;

    ps2_kbd_rx #(
        .FILTER_LEN(4),
        .TIMEOUT_CYCLES(TO),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .rx_data(rx_data),
        .rx_parity_err(rx_parity_err),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .frame_err(frame_err),
        .overflow(overflow),
        .busy(busy)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #(10 * 80000);
        $display("FAIL watchdog: simulation did not complete within 80000 cycles");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every consumed beat against the scoreboard, count frame_err pulses.
    initial begin
        logic [8:0] exp;
        forever begin
            @(negedge clk);
            if (!rst && frame_err) fe_cnt++;
            if (!rst && rx_valid && rx_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_beat: got %0h expected none", {rx_parity_err, rx_data});
                end else begin
                    exp = exp_q.pop_front();
                    if ({rx_parity_err, rx_data} !== exp) begin
                        n_err++;
                        $display("FAIL rx_beat: got %0h expected %0h", {rx_parity_err, rx_data}, exp);
                    end
                end
            end
        end
    end

    // Driver: one PS/2 bit, data set while the clock is high, optional glitch.
    task automatic send_bit(input logic b, input bit glitch, input bit pop_on_commit);
        ps2_data = b;
        if (glitch) begin
            repeat (H / 2) tick();
            ps2_clk = 1'b0;
            repeat (2) tick();
            ps2_clk = 1'b1;
            repeat (H / 2 - 2) tick();
        end else begin
            repeat (H) tick();
        end
        ps2_clk = 1'b0;
        if (pop_on_commit) begin
            // Commit lands 6 edges after the pin falls; raise ready so the pop shares that edge.
            repeat (5) tick();
            rx_ready = 1'b1;
            repeat (H - 5) tick();
        end else begin
            repeat (H) tick();
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                              input int glitch_bit, input bit pop_on_commit);
        logic [10:0] bits;
        bits = {stp, par, b, 1'b0};
        for (int i = 0; i < 11; i++)
            send_bit(bits[i], i == glitch_bit, (i == 10) && pop_on_commit);
        ps2_data = 1'b1;
        repeat (3 * H) tick();
    endtask

    task automatic send_partial(input logic [7:0] b, input int n);
        send_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) send_bit(b[i], 1'b0, 1'b0);
        ps2_data = 1'b1;
        repeat (H) tick();
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 2000) begin
            tick();
            k++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    // Stimulus sequence.
    initial begin
        logic [7:0] fill_b [4];
        logic [7:0] ov_b   [5];
        logic       ov_p   [5];
        fill_b = '{8'h11, 8'h12, 8'h14, 8'h18};
        ov_b   = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        ov_p   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        do_reset();
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_parity_err", rx_parity_err, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_overflow", overflow, 0);
        check("reset_busy", busy, 0);

        // Valid bytes and a parity error.
        rx_ready = 1'b1;
        exp_q.push_back({1'b0, 8'h1C}); send_frame(8'h1C, 1'b0, 1'b1, -1, 1'b0);
        exp_q.push_back({1'b0, 8'hF0}); send_frame(8'hF0, 1'b1, 1'b1, -1, 1'b0);
        exp_q.push_back({1'b1, 8'h1C}); send_frame(8'h1C, 1'b1, 1'b1, -1, 1'b0);
        wait_drain("drain_basic");
        check("no_frame_err_basic", fe_cnt, 0);

        // Bad stop bit.
        send_frame(8'h5A, 1'b1, 1'b0, -1, 1'b0);
        check("bad_stop_frame_err", fe_cnt, 1);
        check("bad_stop_busy", busy, 0);
        check("bad_stop_no_valid", rx_valid, 0);

        // Timeout after start + 4 data bits.
        send_partial(8'h5A, 4);
        check("partial_busy", busy, 1);
        repeat (TO - 1000) tick();
        check("before_timeout_busy", busy, 1);
        check("before_timeout_frame_err", fe_cnt, 1);
        repeat (1100) tick();
        check("timeout_frame_err", fe_cnt, 2);
        check("timeout_busy", busy, 0);
        exp_q.push_back({1'b0, 8'h5A}); send_frame(8'h5A, 1'b1, 1'b1, -1, 1'b0);
        wait_drain("drain_after_timeout");

        // Glitch rejection in idle and mid-frame.
        ps2_clk = 1'b0; repeat (2) tick(); ps2_clk = 1'b1;
        repeat (2 * H) tick();
        check("idle_glitch_busy", busy, 0);
        check("idle_glitch_frame_err", fe_cnt, 2);
        exp_q.push_back({1'b0, 8'h33}); send_frame(8'h33, 1'b1, 1'b1, 4, 1'b0);
        wait_drain("drain_glitch");
        check("glitch_frame_err", fe_cnt, 2);

        // Full storage plus a pop on the commit edge: no overflow.
        rx_ready = 1'b0;
        for (int i = 0; i < CAP; i++) begin
            exp_q.push_back({1'b0, fill_b[i]});
            send_frame(fill_b[i], 1'b1, 1'b1, -1, 1'b0);
        end
        check("full_valid", rx_valid, 1);
        exp_q.push_back({1'b0, 8'h21}); send_frame(8'h21, 1'b1, 1'b1, -1, 1'b1);
        check("full_pop_no_overflow", overflow, 0);
        wait_drain("drain_full_pop");
        check("full_pop_no_overflow_after", overflow, 0);

        // Overflow with the consumer stalled.
        rx_ready = 1'b0;
        for (int i = 0; i <= CAP; i++) begin
            if (i < CAP) exp_q.push_back({1'b0, ov_b[i]});
            send_frame(ov_b[i], ov_p[i], 1'b1, -1, 1'b0);
        end
        check("overflow_set", overflow, 1);
        rx_ready = 1'b1;
        wait_drain("drain_overflow");
        repeat (5) tick();
        check("overflow_sticky", overflow, 1);
        check("overflow_drained_valid", rx_valid, 0);

        // Reset mid-frame with a stored entry: everything is flushed.
        rx_ready = 1'b0;
        send_frame(8'h01, 1'b0, 1'b1, -1, 1'b0);
        send_partial(8'h77, 3);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_valid", rx_valid, 1);
        do_reset();
        check("rst_flush_valid", rx_valid, 0);
        check("rst_flush_busy", busy, 0);
        check("rst_flush_overflow", overflow, 0);
        check("rst_flush_rx_data", rx_data, 8'h00);
        rx_ready = 1'b1;
        exp_q.push_back({1'b0, 8'h1C}); send_frame(8'h1C, 1'b0, 1'b1, -1, 1'b0);
        wait_drain("drain_after_rst");

        repeat (10) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
